tt_sweep_gen: RTL

- Sequential stimulus/capture stage that sits directly upstream of a small combinational gate (and4gate class, N inputs, 1 output).
- Drives the gate's inputs through all 2**N_IN combinations in binary order, waits a settle interval per vector, samples the gate output and builds the gate's truth table.
- Replaces hand-written per-vector stimulus with one synthesizable sweeper. Result is a packed truth-table word, read once done is high.

---
 rtl/tt_sweep_gen_if.sv | 38 +++
 rtl/tt_sweep_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/tt_sweep_gen_if.sv
// Bundle between the truth-table sweeper and the gate it characterises.
// TT_CHECK_EN adds the golden-table compare signals.
interface tt_sweep_gen_if #(
  parameter int N_IN = 4
);
  localparam int NVEC = 1 << N_IN;

  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic [N_IN-1:0] vec_idx;
  logic            busy;
  logic            done;
  logic [NVEC-1:0] truth;
`ifdef TT_CHECK_EN
  logic [NVEC-1:0] expected;
  logic [N_IN:0]   mismatch_cnt;
  logic            pass;
`endif

  modport master (
    input  start, dut_out,
`ifdef TT_CHECK_EN
    input  expected,
    output mismatch_cnt, pass,
`endif
    output dut_in, vec_idx, busy, done, truth
  );

  modport slave (
    output start, dut_out,
`ifdef TT_CHECK_EN
    output expected,
    input  mismatch_cnt, pass,
`endif
    input  dut_in, vec_idx, busy, done, truth
  );
endinterface

// File: rtl/tt_sweep_gen.sv
// Walks a small gate through all 2**N_IN input vectors and captures its truth table.
// TT_CHECK_EN: compare each sample against a golden table, count mismatches, flag pass.
module tt_sweep_gen #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_sweep_gen_if.master bus
);
  localparam int NVEC = 1 << N_IN;
  localparam int CW   = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NVEC-1:0] truth_q, truth_d;
`ifdef TT_CHECK_EN
  logic [N_IN:0]   mism_q, mism_d;
  logic            pass_q, pass_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= '0;
`ifdef TT_CHECK_EN
      mism_q  <= '0;
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      truth_q <= truth_d;
`ifdef TT_CHECK_EN
      mism_q  <= mism_d;
      pass_q  <= pass_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    truth_d = truth_q;
`ifdef TT_CHECK_EN
    mism_d  = mism_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        // A start in DONE restarts exactly like one in IDLE
        if (bus.start) begin
          state_d = SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          truth_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef TT_CHECK_EN
          mism_d  = '0;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      SAMPLE: begin
        truth_d[vec_q] = bus.dut_out;
`ifdef TT_CHECK_EN
        if (bus.dut_out != bus.expected[vec_q] && mism_q != (N_IN+1)'(NVEC))
          mism_d = mism_q + 1'b1;
`endif
        // Terminal check comes first so vec_idx never wraps
        if (vec_q == N_IN'(NVEC - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TT_CHECK_EN
    pass_d = done_d && (mism_d == '0);
`endif
  end

  // dut_in and vec_idx share one register, so the gate sees a glitch-free vector
  assign bus.dut_in  = vec_q;
  assign bus.vec_idx = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.truth   = truth_q;
`ifdef TT_CHECK_EN
  assign bus.mismatch_cnt = mism_q;
  assign bus.pass         = pass_q;
`endif
endmodule
